heap_pq_seq: RTL and testbench
==============================

Name: heap_pq_seq

Overview:
- Clocked, parametrised min-priority queue; successor to the combinational path-based queue step function.
- Holds the queue in a register-array binary heap; commands arrive over a valid/ready handshake.
- Push does a sequential sift-up and pop a sequential sift-down, one heap level per cycle.
- Sits between the command arbiter and the consumer; replaces the single-cycle, fixed-size step function.

Parameters:
- DATA_W, 64, width of an element; whole element is the unsigned priority key, smaller = higher priority.
- LEVELS, 10, heap depth; capacity CAP = 2^LEVELS - 1 (1023).
- CNT_W, LEVELS, width of the occupancy count and heap index.

Ports:
- system1000  in  1  clock; all state updates on rising edge.
- system1000_rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 push, 01 pop, 10 nop, 11 reserved (treated as nop).
- cmd_data  in  DATA_W  push operand.
- rsp_valid  out  1  one-cycle pulse per accepted pop or rejected push.
- rsp_data  out  DATA_W  popped element; 0 when rsp_err=1.
- rsp_err  out  1  pop on empty, or push on full.
- top_valid  out  1  queue non-empty.
- top_data  out  DATA_W  current minimum (heap[1]); 0 when empty.
- count  out  CNT_W  number of stored elements, 0..CAP.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - all heap entries, count, rsp_* and top_data = 0; FSM = IDLE; cmd_ready = 1.
  - Reset mid-sift aborts the sift and empties the queue.
- Storage: heap[1..CAP], 1-based; parent(i) = i>>1; children 2i and 2i+1.
- FSM states: IDLE, SIFT_UP, SIFT_DOWN.
- Accept = cmd_valid & cmd_ready; commands are accepted only in IDLE.
- Push, not full (accepted in IDLE):
  - heap[count+1] <= cmd_data; count++; idx <= count+1.
  - If idx = 1, stay in IDLE; otherwise go to SIFT_UP.
- SIFT_UP, per cycle:
  - if idx > 1 and heap[idx] < heap[parent], swap the two and set idx <= parent.
  - otherwise go to IDLE.
  - Equal keys do not swap.
  - Worst case LEVELS-1 swap cycles plus 1 terminating cycle.
- Push when count = CAP: no state change; next cycle rsp_valid=1, rsp_err=1; stay in IDLE.
- Pop, not empty (accepted in IDLE):
  - next cycle rsp_valid=1, rsp_err=0, rsp_data = old heap[1].
  - heap[1] <= heap[count]; heap[count] <= 0; count--; idx <= 1.
  - If the new count <= 1, stay in IDLE; otherwise go to SIFT_DOWN.
- SIFT_DOWN, per cycle:
  - c = smaller of the children that lie within count; left wins ties.
  - if c exists and heap[c] < heap[idx], swap and set idx <= c.
  - otherwise go to IDLE.
- Pop when count = 0: next cycle rsp_valid=1, rsp_err=1, rsp_data=0.
- Nop/reserved op: accepted, no effect, no response.
- top_data/top_valid are registered views of heap[1]/count!=0. They are valid and stable only while busy=0; during sifts they may show intermediate values.
- count and busy update in the same cycle as the accepting edge.
- Heap invariant heap[parent(i)] <= heap[i] holds for all 1 < i <= count whenever busy=0.
- Comparison is unsigned over the full DATA_W.

Decomposition:
- Package pq_pkg holds:
  - op codes OP_PUSH=2'b00, OP_POP=2'b01, OP_NOP=2'b10;
  - FSM state enum {IDLE, SIFT_UP, SIFT_DOWN};
  - helper functions parent_idx/left_idx.
- One sub-module, pq_min_sel: combinational three-way select (node, left, right, plus child-present flags) returning the winner index and a swap flag. It is used by SIFT_DOWN; SIFT_UP uses its two-input case.

Test Plan:
- Reset, then pop -> rsp_valid=1, rsp_err=1, rsp_data=0, count=0, top_valid=0.
- Push 5, 3, 8, 1 (wait for busy=0 between pushes) -> top_data=1, count=4. Then pop x4 -> rsp_data 1, 3, 5, 8; then count=0.
- Push equal keys 7, 7, 7 then pop x3 -> three 7s, rsp_err=0. The sift loops terminate: busy falls within LEVELS cycles.
- Push descending CAP..1 with LEVELS=4 (CAP=15) -> each push sifts to root, taking up to 4 busy cycles. A 16th push gives rsp_err=1 and count stays 15.
- Hold cmd_valid with pop while busy=1 -> cmd_ready=0, no accept until IDLE, and exactly one response per accepted pop.
- Assert system1000_rstn low during a SIFT_DOWN -> outputs go to reset values immediately. After release, count=0 and cmd_ready=1.

Source files
------------

// File: rtl/heap_pq_seq_pkg.sv
// pq_pkg: shared definitions for the sequential heap priority queue.
//   - command op codes carried on cmd_op
//   - FSM state encoding (IDLE, SIFT_UP, SIFT_DOWN)
//   - 1-based binary-heap index helpers (parent / left child)
package pq_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SIFT_UP   = 2'd1,
    SIFT_DOWN = 2'd2
  } state_e;

  // Parent of heap slot i (root is slot 1).
  function automatic int unsigned parent_idx(input int unsigned i);
    return i >> 1;
  endfunction

  // Left child of heap slot i; the right child is left_idx(i) + 1.
  function automatic int unsigned left_idx(input int unsigned i);
    return i << 1;
  endfunction

endpackage

// File: rtl/heap_pq_seq_if.sv
// heap_pq_seq_if: command / response / status bundle of the heap queue.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command handshake (master -> queue)
//   rsp_valid/rsp_data/rsp_err          : one-cycle response pulse (queue -> master)
//   top_valid/top_data/count/busy       : status view of the queue
// Modports: master (command issuer), slave (the queue itself).
interface heap_pq_seq_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 10
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              top_valid;
  logic [DATA_W-1:0] top_data;
  logic [CNT_W-1:0]  count;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  top_valid, top_data, count, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output top_valid, top_data, count, busy
  );

endinterface

// File: rtl/heap_pq_seq_min_sel.sv
// pq_min_sel: combinational three-way minimum select for heap sifting.
//   node_*  : value/index of the node being sifted
//   left_*  : first candidate (left child, or the sifting node in sift-up)
//   right_* : second candidate (right child); ignored unless right_ok_i
//   win_idx_o : index holding the smallest value (node index if no swap)
//   swap_o    : a candidate is strictly smaller than the node
// A right candidate is only meaningful when a left one exists; ties between
// the two candidates go left, and an equal candidate never displaces the node.
module pq_min_sel #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 10
) (
  input  logic [DATA_W-1:0] node_val_i,
  input  logic [IDX_W-1:0]  node_idx_i,
  input  logic [DATA_W-1:0] left_val_i,
  input  logic [IDX_W-1:0]  left_idx_i,
  input  logic              left_ok_i,
  input  logic [DATA_W-1:0] right_val_i,
  input  logic [IDX_W-1:0]  right_idx_i,
  input  logic              right_ok_i,
  output logic [IDX_W-1:0]  win_idx_o,
  output logic              swap_o
);

  logic [DATA_W-1:0] cand_val_s;
  logic [IDX_W-1:0]  cand_idx_s;

  // Pick the smaller candidate, then decide whether it beats the node.
  always_comb begin
    cand_val_s = left_val_i;
    cand_idx_s = left_idx_i;
    win_idx_o  = node_idx_i;
    swap_o     = 1'b0;
    if (left_ok_i && right_ok_i && (right_val_i < left_val_i)) begin
      cand_val_s = right_val_i;
      cand_idx_s = right_idx_i;
    end else begin
      cand_val_s = left_val_i;
      cand_idx_s = left_idx_i;
    end
    if (left_ok_i && (cand_val_s < node_val_i)) begin
      win_idx_o = cand_idx_s;
      swap_o    = 1'b1;
    end else begin
      win_idx_o = node_idx_i;
      swap_o    = 1'b0;
    end
  end

endmodule

// File: rtl/heap_pq_seq.sv
// heap_pq_seq: clocked min-priority queue kept as a 1-based register-array
// binary heap. Push sifts up and pop sifts down, one heap level per cycle.
//   system1000       : clock, rising edge
//   system1000_rstn  : asynchronous active-low reset
//   bus (slave)      : command handshake, response pulse, status view
// Parameters: DATA_W element width (unsigned key, smaller wins),
//             LEVELS heap depth (capacity 2^LEVELS-1), CNT_W count width.
module heap_pq_seq
  import pq_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LEVELS = 10,
  parameter int CNT_W  = LEVELS
) (
  input  logic          system1000,
  input  logic          system1000_rstn,
  heap_pq_seq_if.slave  bus
);

  localparam int               CAP    = (1 << LEVELS) - 1;
  localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAP);
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C  = CNT_W'(2);
  localparam logic [DATA_W-1:0] DZERO = {DATA_W{1'b0}};

  // Slot 0 is never written; it only keeps the array indexable by any
  // CNT_W-bit value without range checks.
  logic [DATA_W-1:0] heap_q [0:CAP];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] top_data_q, top_data_d;
  logic              top_valid_q, top_valid_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  // Two heap write ports: a swap needs both; a pop moves the last entry to
  // the root (port 0) and clears the vacated slot (port 1, wins on overlap).
  logic              wr0_en_s, wr1_en_s;
  logic [CNT_W-1:0]  wr0_idx_s, wr1_idx_s;
  logic [DATA_W-1:0] wr0_val_s, wr1_val_s;

  logic [CNT_W-1:0]  par_idx_s;
  logic [CNT_W:0]    left_w_s, right_w_s;

  logic [DATA_W-1:0] sel_node_val_s, sel_left_val_s, sel_right_val_s;
  logic [CNT_W-1:0]  sel_node_idx_s, sel_left_idx_s, sel_right_idx_s;
  logic              sel_left_ok_s, sel_right_ok_s;
  logic [CNT_W-1:0]  sel_win_idx_s;
  logic              sel_swap_s;

  // Child indices are one bit wider so slots beyond CAP compare correctly.
  assign par_idx_s = CNT_W'(parent_idx(32'(idx_q)));
  assign left_w_s  = (CNT_W + 1)'(left_idx(32'(idx_q)));
  assign right_w_s = left_w_s + (CNT_W + 1)'(1);

  // Route heap nodes to the selector: sift-up compares idx against its parent
  // (two-input case), sift-down compares idx against its children.
  always_comb begin
    sel_node_val_s  = heap_q[idx_q];
    sel_node_idx_s  = idx_q;
    sel_left_val_s  = heap_q[left_w_s[CNT_W-1:0]];
    sel_left_idx_s  = left_w_s[CNT_W-1:0];
    sel_left_ok_s   = 1'b0;
    sel_right_val_s = heap_q[right_w_s[CNT_W-1:0]];
    sel_right_idx_s = right_w_s[CNT_W-1:0];
    sel_right_ok_s  = 1'b0;
    if (state_q == SIFT_UP) begin
      sel_node_val_s  = heap_q[par_idx_s];
      sel_node_idx_s  = par_idx_s;
      sel_left_val_s  = heap_q[idx_q];
      sel_left_idx_s  = idx_q;
      sel_left_ok_s   = (idx_q > ONE_C);
      sel_right_ok_s  = 1'b0;
    end else begin
      sel_left_ok_s   = (left_w_s  <= {1'b0, count_q});
      sel_right_ok_s  = (right_w_s <= {1'b0, count_q});
    end
  end

  pq_min_sel #(
    .DATA_W (DATA_W),
    .IDX_W  (CNT_W)
  ) u_min_sel (
    .node_val_i  (sel_node_val_s),
    .node_idx_i  (sel_node_idx_s),
    .left_val_i  (sel_left_val_s),
    .left_idx_i  (sel_left_idx_s),
    .left_ok_i   (sel_left_ok_s),
    .right_val_i (sel_right_val_s),
    .right_idx_i (sel_right_idx_s),
    .right_ok_i  (sel_right_ok_s),
    .win_idx_o   (sel_win_idx_s),
    .swap_o      (sel_swap_s)
  );

  // FSM next state, heap write requests, response and status next values.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    wr0_en_s    = 1'b0;
    wr0_idx_s   = ZERO_C;
    wr0_val_s   = DZERO;
    wr1_en_s    = 1'b0;
    wr1_idx_s   = ZERO_C;
    wr1_val_s   = DZERO;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = DZERO;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_PUSH: begin
              if (count_q == CAP_C) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
              end else begin
                wr0_en_s  = 1'b1;
                wr0_idx_s = count_q + ONE_C;
                wr0_val_s = bus.cmd_data;
                count_d   = count_q + ONE_C;
                idx_d     = count_q + ONE_C;
                if (count_q == ZERO_C) begin
                  state_d = IDLE;
                end else begin
                  state_d = SIFT_UP;
                end
              end
            end
            OP_POP: begin
              if (count_q == ZERO_C) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
              end else begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = heap_q[1];
                wr0_en_s    = 1'b1;
                wr0_idx_s   = ONE_C;
                wr0_val_s   = heap_q[count_q];
                wr1_en_s    = 1'b1;
                wr1_idx_s   = count_q;
                wr1_val_s   = DZERO;
                count_d     = count_q - ONE_C;
                idx_d       = ONE_C;
                if (count_q <= TWO_C) begin
                  state_d = IDLE;
                end else begin
                  state_d = SIFT_DOWN;
                end
              end
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      SIFT_UP: begin
        if (sel_swap_s) begin
          wr0_en_s  = 1'b1;
          wr0_idx_s = par_idx_s;
          wr0_val_s = heap_q[idx_q];
          wr1_en_s  = 1'b1;
          wr1_idx_s = idx_q;
          wr1_val_s = heap_q[par_idx_s];
          idx_d     = par_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      SIFT_DOWN: begin
        if (sel_swap_s) begin
          wr0_en_s  = 1'b1;
          wr0_idx_s = idx_q;
          wr0_val_s = heap_q[sel_win_idx_s];
          wr1_en_s  = 1'b1;
          wr1_idx_s = sel_win_idx_s;
          wr1_val_s = heap_q[idx_q];
          idx_d     = sel_win_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d      = (state_d != IDLE);
    ready_d     = (state_d == IDLE);
    top_valid_d = (count_d != ZERO_C);
    // Root view follows whichever port lands on slot 1 this cycle.
    if (wr1_en_s && (wr1_idx_s == ONE_C)) begin
      top_data_d = wr1_val_s;
    end else if (wr0_en_s && (wr0_idx_s == ONE_C)) begin
      top_data_d = wr0_val_s;
    end else begin
      top_data_d = heap_q[1];
    end
  end

  // Control, response and status registers.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q     <= IDLE;
      count_q     <= ZERO_C;
      idx_q       <= ZERO_C;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= DZERO;
      top_data_q  <= DZERO;
      top_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      top_data_q  <= top_data_d;
      top_valid_q <= top_valid_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  // Heap storage; port 1 is applied after port 0 so it wins on overlap.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i <= CAP; i++) begin
        heap_q[i] <= DZERO;
      end
    end else begin
      if (wr0_en_s) begin
        heap_q[wr0_idx_s] <= wr0_val_s;
      end
      if (wr1_en_s) begin
        heap_q[wr1_idx_s] <= wr1_val_s;
      end
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.top_valid = top_valid_q;
  assign bus.top_data  = top_data_q;
  assign bus.count     = count_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_heap_pq_seq.sv
// Bench for heap_pq_seq with LEVELS=4 (capacity 15). A driver issues
// commands and updates a queue-based reference model; expected responses go
// into a scoreboard queue that a negedge monitor drains as rsp_valid pulses.
module tb_heap_pq_seq;
  import pq_pkg::*;

  localparam int LV  = 4;
  localparam int CAP = 15;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  heap_pq_seq_if #(.DATA_W(64), .CNT_W(LV)) bus ();

  heap_pq_seq #(.DATA_W(64), .LEVELS(LV)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .bus             (bus)
  );

  typedef struct packed {
    logic        err;
    logic [63:0] data;
  } rsp_t;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] model [$];
  rsp_t        expq  [$];
  rsp_t        mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic int min_pos();
    int p = 0;
    for (int i = 1; i < model.size(); i++) begin
      if (model[i] < model[p]) p = i;
    end
    return p;
  endfunction

  function automatic logic [63:0] model_min();
    if (model.size() == 0) return 64'd0;
    return model[min_pos()];
  endfunction

  // floor(log2(n)) + 1 cycles of sift-up for a new root arriving at slot n
  function automatic int sift_to_root_cycles(input int n);
    int d = 0;
    int v = n;
    if (n <= 1) return 0;
    while (v > 1) begin v = v >> 1; d++; end
    return d + 1;
  endfunction

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn && bus.rsp_valid === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_data=%0h err=%0b, required no response",
                 bus.rsp_data, bus.rsp_err);
      end else begin
        mon_e = expq.pop_front();
        check("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
        check("rsp_data", bus.rsp_data, mon_e.data);
      end
    end
  end

  // Present a command, hold it until accepted, update model on acceptance.
  task automatic issue(input logic [1:0] op, input logic [63:0] d, output int waited);
    int p;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: cmd_ready=%0b after %0d cycles, required 1", bus.cmd_ready, waited);
      bus.cmd_valid = 1'b0;
      return;
    end
    case (op)
      OP_PUSH: begin
        if (model.size() == CAP) expq.push_back('{err: 1'b1, data: 64'd0});
        else model.push_back(d);
      end
      OP_POP: begin
        if (model.size() == 0) begin
          expq.push_back('{err: 1'b1, data: 64'd0});
        end else begin
          p = min_pos();
          expq.push_back('{err: 1'b0, data: model[p]});
          model.delete(p);
        end
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
  endtask

  // Wait for busy to fall (bounded), returning the number of busy cycles.
  task automatic wait_idle(input int bound, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && cyc <= bound) begin
      cyc++;
      @(negedge clk);
    end
    if (bus.busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: busy=%0b after %0d cycles, required 0", bus.busy, cyc);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 64'(bus.count), 64'(model.size()));
    check({tag, "_top_valid"}, 64'(bus.top_valid), 64'(model.size() != 0));
    check({tag, "_top_data"}, bus.top_data, model_min());
    check({tag, "_ready"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  task automatic cmd_idle(input logic [1:0] op, input logic [63:0] d);
    int w;
    int c;
    issue(op, d, w);
    wait_idle(LV + 1, c);
  endtask

  initial begin
    int w;
    int c;
    int n;
    logic [1:0]  op;
    logic [63:0] v;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = 64'd0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_top_valid", 64'(bus.top_valid), 64'd0);
    check("rst_top_data", bus.top_data, 64'd0);
    check("rst_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    rstn = 1'b1;

    // Pop on empty
    cmd_idle(OP_POP, 64'd0);
    check_status("empty_pop");

    // Basic ordering
    cmd_idle(OP_PUSH, 64'd5);
    cmd_idle(OP_PUSH, 64'd3);
    cmd_idle(OP_PUSH, 64'd8);
    cmd_idle(OP_PUSH, 64'd1);
    check_status("basic");
    check("basic_top_is_1", bus.top_data, 64'd1);
    repeat (4) cmd_idle(OP_POP, 64'd0);
    check_status("basic_drained");

    // Equal keys
    repeat (3) cmd_idle(OP_PUSH, 64'd7);
    check_status("equal");
    repeat (3) cmd_idle(OP_POP, 64'd0);

    // Descending fill: every push sifts to the root
    for (int k = 1; k <= CAP; k++) begin
      issue(OP_PUSH, 64'(CAP + 1 - k), w);
      wait_idle(LV + 1, c);
      check("desc_busy_cycles", 64'(c), 64'(sift_to_root_cycles(k)));
    end
    check_status("full");
    cmd_idle(OP_PUSH, 64'd0);
    check_status("full_reject");
    for (int k = 0; k < CAP; k++) cmd_idle(OP_POP, 64'd0);
    check_status("full_drained");

    // Commands held while busy: pop issued right after a root-bound push
    for (int k = 0; k < 5; k++) cmd_idle(OP_PUSH, 64'(10 + k));
    issue(OP_PUSH, 64'd2, w);
    issue(OP_POP, 64'd0, w);
    check("held_pop_stall", 64'(w), 64'(sift_to_root_cycles(6)));
    issue(OP_POP, 64'd0, w);
    check("held_pop2_stalled", 64'(w > 0), 64'd1);
    wait_idle(LV + 1, c);
    check_status("held");
    while (model.size() > 0) cmd_idle(OP_POP, 64'd0);

    // Randomized traffic, including full-width keys and duplicates
    for (int k = 0; k < 300; k++) begin
      n = $urandom_range(0, 9);
      if (n < 5)      op = OP_PUSH;
      else if (n < 9) op = OP_POP;
      else            op = ($urandom_range(0, 1) == 0) ? OP_NOP : 2'b11;
      if ($urandom_range(0, 1) == 0) v = 64'($urandom_range(0, 7));
      else                           v = {$urandom, $urandom};
      cmd_idle(op, v);
      check_status("rand");
    end
    while (model.size() > 0) cmd_idle(OP_POP, 64'd0);

    // Reset asserted during a sift-down
    for (int k = 0; k < 10; k++) cmd_idle(OP_PUSH, {$urandom, $urandom});
    issue(OP_POP, 64'd0, w);
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    model.delete();
    check("mid_rst_count", 64'(bus.count), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_ready", 64'(bus.cmd_ready), 64'd1);
    check("mid_rst_top_valid", 64'(bus.top_valid), 64'd0);
    check("mid_rst_top_data", bus.top_data, 64'd0);
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_status("post_rst");
    cmd_idle(OP_PUSH, 64'h8000_0000_0000_0001);
    cmd_idle(OP_PUSH, 64'h0000_0000_0000_0004);
    check_status("post_rst_push");
    cmd_idle(OP_POP, 64'd0);
    cmd_idle(OP_POP, 64'd0);
    cmd_idle(OP_POP, 64'd0);
    repeat (2) @(negedge clk);

    check("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
